baw_card_engine: RTL and testbench

- Card bookkeeping datapath for the two-player Black-and-White game.
- Each player owns nine cards, valued 0..8. The block tracks which cards each player still holds and latches each player's played card from a one-hot switch selection.
- It reports each player's remaining black/white card counts and the match comparison result.
- It sits between the top-level game FSM (which issues commit/clear strobes) and the display logic; it merges the blackandwhite, compare and encoder functions.

---
 rtl/baw_card_engine.sv | 165 ++++++++++++++++
 tb/tb_baw_card_engine.sv | 214 +++++++++++++++++++++
 2 files changed

// File: rtl/baw_card_engine.sv
// Card bookkeeping for the two-player Black-and-White game.
// Tracks each player's remaining cards and played card. Encodes the one-hot
// switch selection, reports black/white counts and compares the played cards.

// Per-player deck/hand state. The top instantiates one of these per player.
module baw_player #(
   parameter int NCARDS = 9
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              new_game,
   input  logic              new_round,
   input  logic              commit,
   input  logic              sel_valid,
   input  logic [3:0]        sel_code,
   input  logic [NCARDS-1:0] cardselect,
   output logic [NCARDS-1:0] card,
   output logic [NCARDS-1:0] preview,
   output logic [3:0]        handcard,
   output logic [3:0]        black,
   output logic [3:0]        white,
   output logic              reject
);

   logic hit;
   logic accept;

   // With a one-hot selection, "card still held" reduces to an AND/OR test,
   // which avoids indexing the mask with a 4-bit code wider than needed.
   assign hit     = |(card & cardselect);
   assign accept  = commit & sel_valid & hit;
   // Strobes for new game / new round swallow commits without flagging them.
   assign reject  = commit & ~new_game & ~new_round & ~(sel_valid & hit);
   assign preview = card & ~cardselect;

   // Deck mask and played card; game/round strobes take priority over commits.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         card     <= '1;
         handcard <= '0;
      end else if (new_game) begin
         card     <= '1;
         handcard <= '0;
      end else if (new_round) begin
         handcard <= '0;
      end else if (accept) begin
         card     <= card & ~cardselect;
         handcard <= sel_code;
      end
   end

   // Remaining counts by colour: odd values are black, even values are white.
   always_comb begin
      black = '0;
      white = '0;
      for (int i = 0; i < NCARDS; i++) begin
         if (card[i]) begin
            if (i % 2 == 1) black = black + 4'd1;
            else            white = white + 4'd1;
         end
      end
   end

endmodule

module baw_card_engine #(
   parameter int NCARDS = 9,
   parameter int ENC_W  = 16
) (
   input  logic              clk,
   input  logic              resetn,
   input  logic              new_game,
   input  logic              new_round,
   input  logic              p1_commit,
   input  logic              p2_commit,
   input  logic [NCARDS-1:0] cardselect,
   output logic [3:0]        sel_code,
   output logic              sel_valid,
   output logic [NCARDS-1:0] p1_card,
   output logic [NCARDS-1:0] p2_card,
   output logic [NCARDS-1:0] p1_preview,
   output logic [NCARDS-1:0] p2_preview,
   output logic [3:0]        p1_handcard,
   output logic [3:0]        p2_handcard,
   output logic [3:0]        p1_black,
   output logic [3:0]        p1_white,
   output logic [3:0]        p2_black,
   output logic [3:0]        p2_white,
   output logic              p1_isblack,
   output logic              p2_isblack,
   output logic [1:0]        matchresult,
   output logic              commit_err
);

   localparam int NP = 2;

   logic [ENC_W-1:0]             enc_in;
   logic [NP-1:0]                commit;
   logic [NP-1:0]                reject;
   logic [NP-1:0][NCARDS-1:0]    card;
   logic [NP-1:0][NCARDS-1:0]    preview;
   logic [NP-1:0][3:0]           hand;
   logic [NP-1:0][3:0]           black;
   logic [NP-1:0][3:0]           white;

   assign enc_in = {{(ENC_W-NCARDS){1'b0}}, cardselect};
   assign commit = {p2_commit, p1_commit};

   // Priority encoder: highest set bit wins, all-zero input yields 0.
   always_comb begin
      sel_code = '0;
      for (int i = 0; i < ENC_W; i++) begin
         if (enc_in[i]) sel_code = 4'(i);
      end
   end

   // Only a true one-hot selection may be played.
   assign sel_valid = ($countones(cardselect) == 1);

   for (genvar p = 0; p < NP; p++) begin : g_player
      baw_player #(.NCARDS(NCARDS)) u_player (
         .clk        (clk),
         .resetn     (resetn),
         .new_game   (new_game),
         .new_round  (new_round),
         .commit     (commit[p]),
         .sel_valid  (sel_valid),
         .sel_code   (sel_code),
         .cardselect (cardselect),
         .card       (card[p]),
         .preview    (preview[p]),
         .handcard   (hand[p]),
         .black      (black[p]),
         .white      (white[p]),
         .reject     (reject[p])
      );
   end

   // Error pulse: high for the one cycle after any rejected commit.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) commit_err <= 1'b0;
      else         commit_err <= |reject;
   end

   // Round outcome from the two played values; 2'b11 is unreachable.
   always_comb begin
      matchresult = 2'b00;
      if (hand[0] > hand[1])      matchresult = 2'b01;
      else if (hand[1] > hand[0]) matchresult = 2'b10;
   end

   assign p1_card     = card[0];
   assign p2_card     = card[1];
   assign p1_preview  = preview[0];
   assign p2_preview  = preview[1];
   assign p1_handcard = hand[0];
   assign p2_handcard = hand[1];
   assign p1_black    = black[0];
   assign p1_white    = white[0];
   assign p2_black    = black[1];
   assign p2_white    = white[1];
   assign p1_isblack  = hand[0][0];
   assign p2_isblack  = hand[1][0];

endmodule

// File: tb/tb_baw_card_engine.sv
// Directed bench for baw_card_engine with an expected-state scoreboard.
module tb_baw_card_engine;

   logic       clk = 1'b0;
   logic       resetn = 1'b0;
   logic       new_game = 1'b0, new_round = 1'b0;
   logic       p1_commit = 1'b0, p2_commit = 1'b0;
   logic [8:0] cardselect = '0;
   logic [3:0] sel_code;
   logic       sel_valid;
   logic [8:0] p1_card, p2_card, p1_preview, p2_preview;
   logic [3:0] p1_handcard, p2_handcard;
   logic [3:0] p1_black, p1_white, p2_black, p2_white;
   logic       p1_isblack, p2_isblack;
   logic [1:0] matchresult;
   logic       commit_err;

   int n_checks = 0;
   int n_pass   = 0;

   typedef struct {
      logic [8:0] c1, c2;
      logic [3:0] h1, h2;
      logic       err;
   } exp_t;

   exp_t q[$];
   exp_t m;   // bench model of registered state

   baw_card_engine dut (
      .clk(clk), .resetn(resetn), .new_game(new_game), .new_round(new_round),
      .p1_commit(p1_commit), .p2_commit(p2_commit), .cardselect(cardselect),
      .sel_code(sel_code), .sel_valid(sel_valid),
      .p1_card(p1_card), .p2_card(p2_card),
      .p1_preview(p1_preview), .p2_preview(p2_preview),
      .p1_handcard(p1_handcard), .p2_handcard(p2_handcard),
      .p1_black(p1_black), .p1_white(p1_white),
      .p2_black(p2_black), .p2_white(p2_white),
      .p1_isblack(p1_isblack), .p2_isblack(p2_isblack),
      .matchresult(matchresult), .commit_err(commit_err)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
   endtask

   function automatic logic [3:0] f_enc(input logic [8:0] s);
      logic [3:0] r = 4'd0;
      for (int i = 0; i < 9; i++) if (s[i]) r = 4'(i);
      return r;
   endfunction

   // parity 1 counts black (odd) cards, parity 0 white (even) cards
   function automatic logic [3:0] f_cnt(input logic [8:0] mk, input int parity);
      logic [3:0] r = 4'd0;
      for (int i = parity; i < 9; i += 2) if (mk[i]) r = r + 4'd1;
      return r;
   endfunction

   function automatic logic [1:0] f_cmp(input logic [3:0] a, input logic [3:0] b);
      if (a > b) return 2'b01;
      if (b > a) return 2'b10;
      return 2'b00;
   endfunction

   task automatic check_regs(input exp_t e);
      chk("p1_card",     16'(p1_card),     16'(e.c1));
      chk("p2_card",     16'(p2_card),     16'(e.c2));
      chk("p1_handcard", 16'(p1_handcard), 16'(e.h1));
      chk("p2_handcard", 16'(p2_handcard), 16'(e.h2));
      chk("commit_err",  16'(commit_err),  16'(e.err));
      chk("p1_black",    16'(p1_black),    16'(f_cnt(e.c1, 1)));
      chk("p1_white",    16'(p1_white),    16'(f_cnt(e.c1, 0)));
      chk("p2_black",    16'(p2_black),    16'(f_cnt(e.c2, 1)));
      chk("p2_white",    16'(p2_white),    16'(f_cnt(e.c2, 0)));
      chk("p1_isblack",  16'(p1_isblack),  16'(e.h1[0]));
      chk("p2_isblack",  16'(p2_isblack),  16'(e.h2[0]));
      chk("matchresult", 16'(matchresult), 16'(f_cmp(e.h1, e.h2)));
   endtask

   // One clock of stimulus: check combinational outputs, push the expected
   // post-edge state, then pop and compare after the edge.
   task automatic step(input logic ng, input logic nr, input logic c1,
                       input logic c2, input logic [8:0] sel);
      exp_t e;
      logic v;
      @(negedge clk);
      new_game = ng; new_round = nr; p1_commit = c1; p2_commit = c2;
      cardselect = sel;
      #1;
      v = ($countones(sel) == 1);
      chk("sel_code",   16'(sel_code),   16'(f_enc(sel)));
      chk("sel_valid",  16'(sel_valid),  16'(v));
      chk("p1_preview", 16'(p1_preview), 16'(m.c1 & ~sel));
      chk("p2_preview", 16'(p2_preview), 16'(m.c2 & ~sel));
      e = m;
      e.err = 1'b0;
      if (ng) begin
         e.c1 = 9'h1FF; e.c2 = 9'h1FF; e.h1 = 4'd0; e.h2 = 4'd0;
      end else if (nr) begin
         e.h1 = 4'd0; e.h2 = 4'd0;
      end else begin
         if (c1) begin
            if (v && (m.c1 & sel) != 9'd0) begin e.c1 = m.c1 & ~sel; e.h1 = f_enc(sel); end
            else e.err = 1'b1;
         end
         if (c2) begin
            if (v && (m.c2 & sel) != 9'd0) begin e.c2 = m.c2 & ~sel; e.h2 = f_enc(sel); end
            else e.err = 1'b1;
         end
      end
      q.push_back(e);
      m = e;
      @(posedge clk);
      #1;
      new_game = 1'b0; new_round = 1'b0; p1_commit = 1'b0; p2_commit = 1'b0;
      if (q.size() == 0) begin
         n_checks++;
         $error("FAIL scoreboard: got empty queue expected one entry");
      end else begin
         check_regs(q.pop_front());
      end
   endtask

   task automatic reset_model();
      m.c1 = 9'h1FF; m.c2 = 9'h1FF; m.h1 = 4'd0; m.h2 = 4'd0; m.err = 1'b0;
   endtask

   initial begin
      reset_model();
      #12;
      // reset state, explicit constants
      chk("rst_p1_card",  16'(p1_card),     16'h1FF);
      chk("rst_p2_card",  16'(p2_card),     16'h1FF);
      chk("rst_p1_hand",  16'(p1_handcard), 16'h0);
      chk("rst_p2_hand",  16'(p2_handcard), 16'h0);
      chk("rst_p1_black", 16'(p1_black),    16'd4);
      chk("rst_p1_white", 16'(p1_white),    16'd5);
      chk("rst_match",    16'(matchresult), 16'd0);
      chk("rst_err",      16'(commit_err),  16'd0);
      @(negedge clk);
      resetn = 1'b1;

      // p1 plays 5
      step(0, 0, 1, 0, 9'b000100000);
      chk("p1_play5_hand",  16'(p1_handcard), 16'd5);
      chk("p1_play5_card",  16'(p1_card),     16'h1DF);
      chk("p1_play5_black", 16'(p1_black),    16'd3);
      chk("p1_play5_isblk", 16'(p1_isblack),  16'd1);
      // p2 plays 3
      step(0, 0, 0, 1, 9'b000001000);
      chk("p2_play3_hand",  16'(p2_handcard), 16'd3);
      chk("p2_play3_match", 16'(matchresult), 16'b01);
      // new round keeps decks
      step(0, 1, 0, 0, 9'd0);
      chk("nr_p1_card", 16'(p1_card),     16'h1DF);
      chk("nr_p2_card", 16'(p2_card),     16'h1F7);
      chk("nr_match",   16'(matchresult), 16'd0);

      // rejections: replay, multi-hot, empty; idle cycle in between
      step(0, 0, 1, 0, 9'b000100000);
      chk("replay_err", 16'(commit_err), 16'd1);
      step(0, 0, 0, 0, 9'd0);
      chk("err_clears", 16'(commit_err), 16'd0);
      step(0, 0, 1, 0, 9'b000000011);
      chk("multihot_code", 16'(sel_code),  16'd1);
      chk("multihot_vld",  16'(sel_valid), 16'd0);
      chk("multihot_err",  16'(commit_err), 16'd1);
      step(0, 0, 1, 0, 9'd0);
      chk("zero_err", 16'(commit_err), 16'd1);

      // encoder sweep, no commits
      for (int i = 0; i < 9; i++) step(0, 0, 0, 0, 9'(1 << i));

      // simultaneous commits: both accepted, then one accepted one rejected
      step(0, 0, 1, 1, 9'b000000001);
      chk("both_err", 16'(commit_err), 16'd0);
      step(0, 0, 1, 1, 9'b100000000);
      step(0, 0, 1, 1, 9'b000000001);
      step(0, 0, 0, 1, 9'b000000100);
      step(0, 0, 1, 1, 9'b000000100);
      chk("split_err", 16'(commit_err), 16'd1);
      // new round swallows commits silently
      step(0, 1, 1, 1, 9'b000010000);
      // new game with commit: refill, no commit, no error
      step(1, 0, 1, 0, 9'b000000010);
      chk("ng_p1_card", 16'(p1_card),    16'h1FF);
      chk("ng_err",     16'(commit_err), 16'd0);
      step(0, 0, 1, 0, 9'b010000000);
      step(0, 0, 0, 1, 9'b001000000);

      // asynchronous reset mid-cycle
      #2;
      resetn = 1'b0;
      #1;
      chk("async_p1_card", 16'(p1_card),     16'h1FF);
      chk("async_p2_card", 16'(p2_card),     16'h1FF);
      chk("async_p1_hand", 16'(p1_handcard), 16'h0);
      chk("async_p2_hand", 16'(p2_handcard), 16'h0);
      chk("async_err",     16'(commit_err),  16'h0);
      reset_model();
      @(negedge clk);
      resetn = 1'b1;
      step(0, 0, 1, 1, 9'b000000100);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
